// File: rtl/ddr_lane_delay_pkg.sv
// Shared encodings for the DDR lane delay-line sequencer.
package ddr_lane_delay_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_NOP  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK           = 2'd0,
        ST_SATURATED    = 2'd1,
        ST_OUT_OF_RANGE = 2'd2,
        ST_BAD_LANE     = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE,
        S_LOAD,
        S_STEP,
        S_SETTLE,
        S_RELEASE,
        S_DONE
    } state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/ddr_lane_delay_seq_tap_counter.sv
// Saturating up/down tap counter with load-to-INIT_TAP; one per lane per delay line.
module ddr_lane_tap_counter #(
    parameter int TAP_W    = 8,
    parameter int MAX_TAP  = 255,
    parameter int INIT_TAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    output logic [TAP_W-1:0] tap,
    output logic             at_max,
    output logic             at_zero
);
    localparam logic [TAP_W-1:0] MAX_V  = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] INIT_V = TAP_W'(INIT_TAP);

    logic [TAP_W-1:0] tap_q, tap_d;

    assign tap     = tap_q;
    assign at_max  = (tap_q >= MAX_V);
    assign at_zero = (tap_q == '0);

    always_comb begin
        tap_d = tap_q;
        if (load) begin
            tap_d = INIT_V;
        end else if (inc && !at_max) begin
            tap_d = tap_q + TAP_W'(1);
        end else if (dec && !at_zero) begin
            tap_d = tap_q - TAP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tap_q <= INIT_V;
        else     tap_q <= tap_d;
    end

endmodule

// File: rtl/ddr_lane_delay_seq.sv
// Delay-line sequencer: runs LOAD/INC/DEC tap commands on one lane's RX or TX
// DQS delay line, bracketed by an HS_IO_CLK_PAUSE window.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// PAUSE   | clock paused, lead-in before first action
// LOAD    | one-cycle LOAD pulse
// STEP    | one MOVE pulse, or saturation detected
// SETTLE  | wait after LOAD/MOVE, sample out-of-range on last cycle
// RELEASE | clock pause dropped, tail before completion
// DONE    | one-cycle done pulse with status
module ddr_lane_delay_seq
    import ddr_lane_delay_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int TAP_W        = 8,
    parameter int MAX_TAP      = 255,
    parameter int INIT_TAP     = 1,
    parameter int PAUSE_CYCLES = 4,
    parameter int MOVE_SETTLE  = 2,
    localparam int LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       FAB_CLK,
    input  logic                       RESET,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [LANE_W-1:0]          cmd_lane,
    input  logic [1:0]                 cmd_op,
    input  logic                       cmd_line,
    input  logic [TAP_W-1:0]           cmd_steps,
    output logic [NUM_LANES-1:0]       DELAY_LINE_SEL,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
    output logic                       HS_IO_CLK_PAUSE,
    input  logic [NUM_LANES-1:0]       RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic [NUM_LANES-1:0]       TX_DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES*TAP_W-1:0] rx_tap,
    output logic [NUM_LANES*TAP_W-1:0] tx_tap,
    output logic                       done,
    output logic [1:0]                 status
);
    localparam logic [CNT_W-1:0] PAUSE_LAST   = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(MOVE_SETTLE - 1);
    // The DONE cycle is the last cycle of the released window, so RELEASE itself is one shorter.
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((PAUSE_CYCLES > 1) ? PAUSE_CYCLES - 2 : 0);
    localparam state_e           AFTER_ACTION = (PAUSE_CYCLES > 1) ? S_RELEASE : S_DONE;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    status_e             status_q, status_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                line_q, line_d;
    logic [TAP_W-1:0]    steps_q, steps_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_LANES-1:0] rx_max, rx_zero, tx_max, tx_zero;
    logic [NUM_LANES-1:0] rx_load, tx_load, rx_inc, tx_inc, rx_dec, tx_dec;
    logic                 sel_max, sel_zero, sel_oor;
    logic                 line_active, load_act, move_act;

    assign cmd_ready       = (state_q == S_IDLE);
    assign done            = (state_q == S_DONE);
    assign status          = status_q;
    assign HS_IO_CLK_PAUSE = state_q inside {S_PAUSE, S_LOAD, S_STEP, S_SETTLE};
    assign line_active     = state_q inside {S_PAUSE, S_LOAD, S_STEP, S_SETTLE, S_RELEASE};
    assign load_act        = (state_q == S_LOAD);
    assign move_act        = (state_q == S_STEP) && !((op_q == OP_INC) ? sel_max : sel_zero);

    always_comb begin
        sel_max  = 1'b0;
        sel_zero = 1'b0;
        sel_oor  = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_q == LANE_W'(l)) begin
                sel_max  = line_q ? tx_max[l]  : rx_max[l];
                sel_zero = line_q ? tx_zero[l] : rx_zero[l];
                sel_oor  = line_q ? TX_DELAY_LINE_OUT_OF_RANGE[l] : RX_DELAY_LINE_OUT_OF_RANGE[l];
            end
        end
    end

    always_comb begin
        DELAY_LINE_SEL       = '0;
        DELAY_LINE_LOAD      = '0;
        DELAY_LINE_DIRECTION = '0;
        DELAY_LINE_MOVE      = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_q == LANE_W'(l)) begin
                DELAY_LINE_SEL[l]       = line_active & line_q;
                DELAY_LINE_DIRECTION[l] = line_active & (op_q == OP_INC);
                DELAY_LINE_LOAD[l]      = load_act;
                DELAY_LINE_MOVE[l]      = move_act;
            end
        end
        rx_load = DELAY_LINE_LOAD & {NUM_LANES{~line_q}};
        tx_load = DELAY_LINE_LOAD & {NUM_LANES{line_q}};
        rx_inc  = DELAY_LINE_MOVE & DELAY_LINE_DIRECTION & {NUM_LANES{~line_q}};
        tx_inc  = DELAY_LINE_MOVE & DELAY_LINE_DIRECTION & {NUM_LANES{line_q}};
        rx_dec  = DELAY_LINE_MOVE & ~DELAY_LINE_DIRECTION & {NUM_LANES{~line_q}};
        tx_dec  = DELAY_LINE_MOVE & ~DELAY_LINE_DIRECTION & {NUM_LANES{line_q}};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        status_d = status_q;
        lane_d   = lane_q;
        line_d   = line_q;
        steps_d  = steps_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    lane_d   = cmd_lane;
                    op_d     = op_e'(cmd_op);
                    line_d   = cmd_line;
                    steps_d  = cmd_steps;
                    status_d = ST_OK;
                    cnt_d    = PAUSE_LAST;
                    if (int'(cmd_lane) >= NUM_LANES) begin
                        status_d = ST_BAD_LANE;
                        state_d  = S_DONE;
                    end else if (op_e'(cmd_op) == OP_NOP ||
                                 (op_e'(cmd_op) != OP_LOAD && cmd_steps == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (cnt_q == '0) state_d = (op_q == OP_LOAD) ? S_LOAD : S_STEP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_LOAD: begin
                cnt_d   = SETTLE_LAST;
                state_d = S_SETTLE;
            end
            S_STEP: begin
                if (move_act) begin
                    steps_d = steps_q - TAP_W'(1);
                    cnt_d   = SETTLE_LAST;
                    state_d = S_SETTLE;
                end else begin
                    status_d = ST_SATURATED;
                    cnt_d    = RELEASE_LAST;
                    state_d  = AFTER_ACTION;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    cnt_d = RELEASE_LAST;
                    if (sel_oor) begin
                        status_d = ST_OUT_OF_RANGE;
                        state_d  = AFTER_ACTION;
                    end else if (op_q != OP_LOAD && steps_q != '0) begin
                        state_d = S_STEP;
                    end else begin
                        state_d = AFTER_ACTION;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            op_q     <= OP_LOAD;
            status_q <= ST_OK;
            lane_q   <= '0;
            line_q   <= 1'b0;
            steps_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            status_q <= status_d;
            lane_q   <= lane_d;
            line_q   <= line_d;
            steps_q  <= steps_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        ddr_lane_tap_counter #(
            .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .INIT_TAP(INIT_TAP)
        ) u_rx (
            .clk(FAB_CLK), .rst(RESET),
            .load(rx_load[l]), .inc(rx_inc[l]), .dec(rx_dec[l]),
            .tap(rx_tap[l*TAP_W +: TAP_W]), .at_max(rx_max[l]), .at_zero(rx_zero[l])
        );
        ddr_lane_tap_counter #(
            .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .INIT_TAP(INIT_TAP)
        ) u_tx (
            .clk(FAB_CLK), .rst(RESET),
            .load(tx_load[l]), .inc(tx_inc[l]), .dec(tx_dec[l]),
            .tap(tx_tap[l*TAP_W +: TAP_W]), .at_max(tx_max[l]), .at_zero(tx_zero[l])
        );
    end

endmodule

// File: tb/tb_ddr_lane_delay_seq.sv
// Scoreboard bench for ddr_lane_delay_seq: expected outcome queued at command issue,
// popped and compared when done pulses.
module tb_ddr_lane_delay_seq;
    localparam int NL   = 5;
    localparam int TW   = 8;
    localparam int LW   = 3;
    localparam int P    = 4;
    localparam int S    = 2;
    localparam int INIT = 1;

    typedef struct {
        int  status;
        int  lat;
        int  moves;
        int  loads;
        bit  pause;
    } scb_t;

    logic             FAB_CLK = 1'b0;
    logic             RESET   = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LW-1:0]    cmd_lane  = '0;
    logic [1:0]       cmd_op    = 2'd3;
    logic             cmd_line  = 1'b0;
    logic [TW-1:0]    cmd_steps = '0;
    logic [NL-1:0]    sel_o, load_o, dir_o, move_o;
    logic             pause_o;
    logic [NL-1:0]    rx_oor = '0;
    logic [NL-1:0]    tx_oor = '0;
    logic [NL*TW-1:0] rx_tap, tx_tap;
    logic             done;
    logic [1:0]       status;

    int   n_err = 0;
    int   n_chk = 0;
    int   model_rx[NL];
    int   model_tx[NL];
    scb_t scb_q[$];

    always #5 FAB_CLK = ~FAB_CLK;

    ddr_lane_delay_seq #(
        .NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(255), .INIT_TAP(INIT),
        .PAUSE_CYCLES(P), .MOVE_SETTLE(S)
    ) dut (
        .FAB_CLK(FAB_CLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_lane(cmd_lane),
        .cmd_op(cmd_op), .cmd_line(cmd_line), .cmd_steps(cmd_steps),
        .DELAY_LINE_SEL(sel_o), .DELAY_LINE_LOAD(load_o),
        .DELAY_LINE_DIRECTION(dir_o), .DELAY_LINE_MOVE(move_o),
        .HS_IO_CLK_PAUSE(pause_o),
        .RX_DELAY_LINE_OUT_OF_RANGE(rx_oor), .TX_DELAY_LINE_OUT_OF_RANGE(tx_oor),
        .rx_tap(rx_tap), .tx_tap(tx_tap), .done(done), .status(status)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_taps(input string tag);
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("%s_rx%0d", tag, l), int'(rx_tap[l*TW +: TW]), model_rx[l]);
            chk($sformatf("%s_tx%0d", tag, l), int'(tx_tap[l*TW +: TW]), model_tx[l]);
        end
    endtask

    task automatic run_cmd(input string tag, input int lane, input int op, input int line,
                           input int steps, input int oor_after, input int exp_status,
                           input int exp_moves, input int exp_loads, input bit sat,
                           input bit pause);
        scb_t e, got;
        int cyc, moves, loads, pause_cnt, last_pause, first_act, prev_move;
        int other_err, sel_err, spc_err;
        bit seen;
        e.status = exp_status;
        e.moves  = exp_moves;
        e.loads  = exp_loads;
        e.pause  = pause;
        e.lat    = pause ? 2*P + (exp_moves + exp_loads)*(1+S) + int'(sat) : 1;
        scb_q.push_back(e);

        @(negedge FAB_CLK);
        chk({tag, "_ready_pre"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_lane  = LW'(lane);
        cmd_op    = 2'(op);
        cmd_line  = line[0];
        cmd_steps = TW'(steps);
        @(negedge FAB_CLK);
        cmd_valid = 1'b0;
        cmd_lane  = LW'($urandom);
        cmd_op    = 2'($urandom);
        cmd_line  = 1'($urandom);
        cmd_steps = TW'($urandom);

        cyc = 1; moves = 0; loads = 0; pause_cnt = 0; last_pause = 0; first_act = 0;
        prev_move = 0; other_err = 0; sel_err = 0; spc_err = 0; seen = 1'b0;
        while (cyc < 200) begin
            if (pause_o) begin
                pause_cnt++;
                last_pause = cyc;
            end
            for (int l = 0; l < NL; l++) begin
                if (l == lane) begin
                    if (move_o[l]) begin
                        moves++;
                        if (prev_move != 0 && cyc - prev_move != S + 1) spc_err++;
                        prev_move = cyc;
                        if (first_act == 0) first_act = cyc;
                    end
                    if (load_o[l]) begin
                        loads++;
                        if (first_act == 0) first_act = cyc;
                    end
                    if ((pause_o || move_o[l] || load_o[l]) &&
                        (sel_o[l] != line[0] || dir_o[l] != (op == 1))) sel_err++;
                end else if (sel_o[l] || load_o[l] || dir_o[l] || move_o[l]) begin
                    other_err++;
                end
            end
            if (oor_after > 0 && moves == oor_after) begin
                if (line == 0) rx_oor[lane] = 1'b1;
                else           tx_oor[lane] = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge FAB_CLK);
            cyc++;
        end

        chk({tag, "_done_seen"}, int'(seen), 1);
        got = scb_q.pop_front();
        chk({tag, "_status"},  int'(status), got.status);
        chk({tag, "_latency"}, cyc, got.lat);
        chk({tag, "_moves"},   moves, got.moves);
        chk({tag, "_loads"},   loads, got.loads);
        chk({tag, "_other_lanes"}, other_err, 0);
        chk({tag, "_sel_dir"}, sel_err, 0);
        chk({tag, "_move_spacing"}, spc_err, 0);
        if (got.pause) begin
            chk({tag, "_pause_lead"}, first_act, P + 1);
            chk({tag, "_pause_tail"}, cyc - last_pause, P);
        end else begin
            chk({tag, "_pause_none"}, pause_cnt, 0);
        end
        @(negedge FAB_CLK);
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        chk({tag, "_ready_post"}, int'(cmd_ready), 1);
        rx_oor = '0;
        tx_oor = '0;
    endtask

    initial begin
        for (int l = 0; l < NL; l++) begin
            model_rx[l] = INIT;
            model_tx[l] = INIT;
        end
        repeat (3) @(posedge FAB_CLK);
        @(negedge FAB_CLK);
        RESET = 1'b0;
        @(negedge FAB_CLK);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_pause", int'(pause_o), 0);
        chk("rst_status", int'(status), 0);
        chk("rst_ctrl", int'({sel_o, load_o, dir_o, move_o}), 0);
        check_taps("rst");

        run_cmd("inc_l2_tx", 2, 1, 1, 3, 0, 0, 3, 0, 1'b0, 1'b1);
        model_tx[2] = model_tx[2] + 3;
        check_taps("inc_l2_tx");

        run_cmd("dec_l0_rx_sat", 0, 2, 0, 5, 0, 1, 1, 0, 1'b1, 1'b1);
        model_rx[0] = 0;
        check_taps("dec_l0_rx_sat");

        run_cmd("inc_l1_rx_oor", 1, 1, 0, 10, 2, 2, 2, 0, 1'b0, 1'b1);
        model_rx[1] = model_rx[1] + 2;
        check_taps("inc_l1_rx_oor");

        run_cmd("inc_l3_tx", 3, 1, 1, 8, 0, 0, 8, 0, 1'b0, 1'b1);
        model_tx[3] = model_tx[3] + 8;
        check_taps("inc_l3_tx");

        run_cmd("load_l3_tx", 3, 0, 1, 0, 0, 0, 0, 1, 1'b0, 1'b1);
        model_tx[3] = INIT;
        check_taps("load_l3_tx");

        run_cmd("bad_lane", NL, 1, 0, 3, 0, 3, 0, 0, 1'b0, 1'b0);
        run_cmd("nop", 0, 3, 1, 7, 0, 0, 0, 0, 1'b0, 1'b0);
        run_cmd("inc_zero_steps", 4, 1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        check_taps("immediate");

        // Reset during the first SETTLE of a 4-step INC on lane 0 TX.
        @(negedge FAB_CLK);
        cmd_valid = 1'b1;
        cmd_lane  = LW'(0);
        cmd_op    = 2'd1;
        cmd_line  = 1'b1;
        cmd_steps = TW'(4);
        @(negedge FAB_CLK);
        cmd_valid = 1'b0;
        repeat (5) @(negedge FAB_CLK);
        chk("rst_mid_pause_before", int'(pause_o), 1);
        chk("rst_mid_tap_before", int'(tx_tap[0 +: TW]), INIT + 1);
        RESET = 1'b1;
        #1;
        chk("rst_mid_pause_drop", int'(pause_o), 0);
        chk("rst_mid_move_drop", int'(move_o), 0);
        chk("rst_mid_done", int'(done), 0);
        repeat (2) @(negedge FAB_CLK);
        RESET = 1'b0;
        for (int l = 0; l < NL; l++) begin
            model_rx[l] = INIT;
            model_tx[l] = INIT;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge FAB_CLK);
            chk($sformatf("rst_mid_no_done%0d", k), int'(done), 0);
        end
        chk("rst_mid_ready", int'(cmd_ready), 1);
        chk("rst_mid_pause_idle", int'(pause_o), 0);
        check_taps("rst_mid");
        chk("scb_empty", scb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ddr_lane_delay_seq.md
Name: ddr_lane_delay_seq

Overview:
Parametrised delay-line sequencer for the DDR PHY lane controllers.
- Accepts tap-adjust commands from the training logic and drives DELAY_LINE_SEL/LOAD/DIRECTION/MOVE on any of NUM_LANES lanes, for either the RX or the TX DQS delay line.
- Brackets every adjustment with an HS_IO_CLK_PAUSE window.
- Tracks the current tap per lane per line and reports out-of-range and saturation.
- Sits between the training FSM and the lane-controller wrappers (address/command lane and data lanes).

Parameters:
NUM_LANES, 4, number of lane controllers driven (1..16)
TAP_W, 8, width of the tap counters and step count
MAX_TAP, 255, highest legal tap value
INIT_TAP, 1, tap value after reset and after a LOAD operation
PAUSE_CYCLES, 4, FAB_CLK cycles of HS_IO_CLK_PAUSE before the first and after the last delay-line action (>=1)
MOVE_SETTLE, 2, idle cycles after each MOVE or LOAD pulse before sampling out-of-range (>=1)

Ports:
FAB_CLK  in  1  fabric clock; sole clock of the block
RESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_lane  in  clog2(NUM_LANES) (min 1)  target lane
cmd_op  in  2  0=LOAD, 1=INC, 2=DEC, 3=NOP
cmd_line  in  1  0=RX delay line, 1=TX delay line
cmd_steps  in  TAP_W  number of taps for INC/DEC
DELAY_LINE_SEL  out  NUM_LANES  per-lane line select, equals cmd_line for the active lane
DELAY_LINE_LOAD  out  NUM_LANES  one-cycle load pulse
DELAY_LINE_DIRECTION  out  NUM_LANES  1=increment, 0=decrement
DELAY_LINE_MOVE  out  NUM_LANES  one-cycle move pulse per tap
HS_IO_CLK_PAUSE  out  1  clock pause request
RX_DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane RX out-of-range flag
TX_DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane TX out-of-range flag
rx_tap  out  NUM_LANES*TAP_W  flattened RX tap counts
tx_tap  out  NUM_LANES*TAP_W  flattened TX tap counts
done  out  1  one-cycle completion pulse
status  out  2  valid with done: 0=OK, 1=SATURATED, 2=OUT_OF_RANGE, 3=BAD_LANE

Behaviour:
- States: IDLE, PAUSE, LOAD, STEP, SETTLE, RELEASE, DONE.
- Reset values: all outputs 0 except cmd_ready=1; all tap counters = INIT_TAP; state=IDLE.
- Reset mid-operation aborts immediately, with PAUSE and MOVE deasserted asynchronously and no done pulse.
- Accept on cmd_valid && cmd_ready. The command is latched; cmd_ready drops the next cycle.
- Immediate-DONE commands (no pause, no delay-line activity); done occurs in the cycle after accept:
  - NOP, or INC/DEC with cmd_steps=0: status OK.
  - cmd_lane >= NUM_LANES: status BAD_LANE.
- PAUSE: HS_IO_CLK_PAUSE=1 for PAUSE_CYCLES cycles. SEL[lane] and DIRECTION[lane] are set at entry and held constant until RELEASE ends.
  - Non-active lanes: all four controls stay 0.
- LOAD op: DELAY_LINE_LOAD[lane]=1 for one cycle, selected tap := INIT_TAP, then SETTLE.
- INC/DEC step:
  - If tap==MAX_TAP (INC) or tap==0 (DEC): no MOVE pulse, status SATURATED, go to RELEASE.
  - Otherwise MOVE[lane]=1 for one cycle and tap ±1 in that same cycle, then SETTLE.
- SETTLE: MOVE_SETTLE cycles.
  - On its last cycle sample the OOR input for the selected lane and line. If set: status OUT_OF_RANGE (tap is kept as counted), go to RELEASE.
  - Else, if steps remain, go to STEP; otherwise go to RELEASE.
- RELEASE: HS_IO_CLK_PAUSE=0 for PAUSE_CYCLES cycles, then DONE.
- DONE: done=1 and status valid for one cycle, then IDLE.
- Latency from the accept edge to the done cycle (P=PAUSE_CYCLES, S=MOVE_SETTLE):
  - Successful INC/DEC of n steps: 2P + n(1+S).
  - LOAD: 2P + 1 + S.
- Tap arithmetic is unsigned TAP_W wide and never wraps.
- cmd_* inputs are ignored while cmd_ready=0.

Decomposition:
- Package ddr_lane_delay_pkg: op encoding, status encoding, state enum.
- Sub-module ddr_lane_tap_counter: one saturating TAP_W up/down counter with load-to-INIT_TAP and at_max/at_zero flags. Instantiate 2*NUM_LANES copies (RX and TX per lane).

Test Plan:
- Reset, then INC lane 2 TX, 3 steps (P=4, S=2) -> HS_IO_CLK_PAUSE high 4 cycles; MOVE[2] pulses 3 times, 3 cycles apart; DIRECTION[2]=1 and SEL[2]=1 throughout; done at offset 17; tx_tap[2]=4; status OK.
- DEC lane 0 RX, 5 steps from tap 1 -> exactly one MOVE pulse; rx_tap[0]=0; status SATURATED; pause released 4 cycles before done.
- INC lane 1 RX, 10 steps, with RX_DELAY_LINE_OUT_OF_RANGE[1] raised after the 2nd MOVE -> exactly 2 MOVE pulses; rx_tap[1]=3; status OUT_OF_RANGE.
- LOAD lane 3 TX after a previous INC to 9 -> one LOAD[3] pulse; tx_tap[3]=1; done at offset 11.
- cmd_lane=NUM_LANES, and NOP -> done the cycle after accept; no pause; BAD_LANE and OK respectively.
- RESET asserted during SETTLE of a 4-step INC -> PAUSE/MOVE drop immediately; all taps=INIT_TAP; no done; cmd_ready=1 after reset release.
